// File: rtl/bootdata_sender.sv
// bootdata_sender
// Packs a stream of ROM bytes from an SD/SPI byte source into 32-bit
// big-endian words and hands them one at a time to the ROM loader. A
// transfer starts with a one-cycle loader reset pulse. Each word then uses a
// req/ack handshake with a per-word acknowledge timeout.
//
// Handshakes:
//   byte side  : a byte moves on a rising edge where i_byte_valid && o_byte_ready;
//                o_byte_ready is high only in FILL, so byte_valid is a don't-care elsewhere.
//   loader side: o_host_bootdata_req stays high with o_host_bootdata stable until
//                i_host_bootdata_ack is sampled high in REQ (ack may coincide with
//                the first req cycle); ack outside REQ is ignored.

module bootdata_sender #(
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [15:0] i_size,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    output logic [31:0] o_host_bootdata,
    output logic        o_host_bootdata_req,
    input  logic        i_host_bootdata_ack,
    output logic        o_host_bootdata_reset,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [2:0]  o_dbg_state
);

    // The counter only has to hold ACK_TIMEOUT-1 (the value in the last
    // allowed REQ cycle).
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_FILL = 3'd2,
        S_REQ  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [15:0]   r_bytes_left;
    logic [1:0]    r_byte_idx;
    logic [31:0]   r_word;
    logic [TW-1:0] r_timeout;
    logic          r_error;

    logic          w_start;
    logic          w_byte_fire;
    logic          w_word_full;
    logic          w_ack;
    logic          w_timeout;
    logic [4:0]    w_lane_lo;

    // Qualified events shared by the next-state logic and the datapath.
    always_comb begin
        w_start     = (r_state == S_IDLE) && i_start;
        w_byte_fire = (r_state == S_FILL) && i_byte_valid;
        // A word is complete on its 4th byte or on the last byte of the transfer.
        w_word_full = w_byte_fire && ((r_byte_idx == 2'd3) || (r_bytes_left == 16'd1));
        w_ack       = (r_state == S_REQ) && i_host_bootdata_ack;
        w_timeout   = (r_state == S_REQ) && !i_host_bootdata_ack && (r_timeout == TO_LAST);
        // Byte k of a word lands in lane 3-k; for a 2-bit index 3-k is ~k.
        w_lane_lo   = {~r_byte_idx, 3'b000};
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_RST;
                end
            end
            S_RST: begin
                w_next_state = (r_bytes_left != 16'd0) ? S_FILL : S_DONE;
            end
            S_FILL: begin
                if (w_word_full) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    w_next_state = (r_bytes_left != 16'd0) ? S_FILL : S_DONE;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode: every handshake/status output is a pure function of state.
    always_comb begin
        o_byte_ready          = 1'b0;
        o_host_bootdata_req   = 1'b0;
        o_host_bootdata_reset = 1'b0;
        o_busy                = 1'b0;
        o_done                = 1'b0;
        case (r_state)
            S_RST: begin
                o_host_bootdata_reset = 1'b1;
                o_busy                = 1'b1;
            end
            S_FILL: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
            S_REQ: begin
                o_host_bootdata_req = 1'b1;
                o_busy              = 1'b1;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // Byte counter, lane index, word assembly and the sticky error flag.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_bytes_left <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_word       <= 32'd0;
            r_error      <= 1'b0;
        end else begin
            if (w_start) begin
                r_bytes_left <= i_size;
                r_byte_idx   <= 2'd0;
                r_word       <= 32'd0;
                r_error      <= 1'b0;
            end
            if (w_byte_fire) begin
                r_word[w_lane_lo +: 8] <= i_byte_data;
                r_bytes_left           <= r_bytes_left - 16'd1;
                r_byte_idx             <= w_word_full ? 2'd0 : (r_byte_idx + 2'd1);
            end
            // The word register clears once the loader has taken the word, so a
            // final partial word always starts from zero lanes.
            if (w_ack) begin
                r_word     <= 32'd0;
                r_byte_idx <= 2'd0;
            end
            if (w_timeout) begin
                r_word  <= 32'd0;
                r_error <= 1'b1;
            end
        end
    end

    // Ack timeout counter: held at zero outside REQ, so it starts from zero on
    // every REQ entry and counts REQ cycles that pass without an ack.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_timeout <= '0;
        end else if (r_state != S_REQ) begin
            r_timeout <= '0;
        end else if (!i_host_bootdata_ack) begin
            r_timeout <= r_timeout + 1'b1;
        end
    end

    // Registered values straight to the ports.
    always_comb begin
        o_host_bootdata = r_word;
        o_error         = r_error;
        o_dbg_state     = r_state;
    end

endmodule

// File: doc/bootdata_sender.md
BOOTDATA_SENDER -- requirements
Module: bootdata_sender

Interface
REQ-001 Parameter ACK_TIMEOUT, default 65535: maximum clk cycles spent waiting for host_bootdata_ack per word before error.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  one-cycle pulse that begins a transfer; sampled only in IDLE.
REQ-005 size  input  16  transfer length in bytes, captured on the accepted start.
REQ-006 byte_valid  input  1  byte source has byte_data available.
REQ-007 byte_data  input  8  ROM byte from the SD/SPI byte source.
REQ-008 byte_ready  output  1  sender accepts byte_data this cycle; a byte transfers when byte_valid && byte_ready.
REQ-009 host_bootdata  output  32  packed word presented to the ROM loader.
REQ-010 host_bootdata_req  output  1  word valid; held until acknowledged.
REQ-011 host_bootdata_ack  input  1  loader acknowledge pulse.
REQ-012 host_bootdata_reset  output  1  one-cycle pulse telling the loader to restart its address counter.
REQ-013 busy  output  1  high in every state except IDLE and DONE.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 error  output  1  sticky ack-timeout flag; cleared by the next accepted start or by reset.

Function
REQ-016 States are IDLE, RST, FILL, REQ and DONE; encoding is free.
REQ-017 IDLE + start: capture size into bytes_left, clear error, go to RST.
REQ-018 start in any other state shall be ignored.
REQ-019 RST: assert host_bootdata_reset for exactly one cycle; next state is FILL if bytes_left != 0, else DONE.
REQ-020 FILL: byte_ready = 1; each accepted byte enters lane 3-k, where k is the byte index within the word, so the first byte goes to [31:24] (big-endian).
REQ-021 Each accepted byte decrements bytes_left by 1.
REQ-022 FILL goes to REQ in the cycle after the 4th byte of a word or the last byte of the transfer is accepted.
REQ-023 Unfilled lanes of a final partial word shall be 0x00.
REQ-024 byte_ready = 0 in all states other than FILL; byte_valid is ignored there.
REQ-025 REQ: host_bootdata_req = 1 and host_bootdata stable while req is high.
REQ-026 In REQ, when host_bootdata_ack = 1 is sampled, req drops on the next edge, the word register clears, and the state goes to FILL if bytes_left != 0, else DONE.
REQ-027 Ack may arrive in the same cycle req first rises; it is honoured.
REQ-028 host_bootdata_ack outside REQ shall be ignored.
REQ-029 Timeout counter: cleared on entry to REQ and incremented each REQ cycle without ack.
REQ-030 When the timeout counter reaches ACK_TIMEOUT: drop req, set error, return to IDLE with no done pulse.
REQ-031 DONE: pulse done for one cycle, then go to IDLE.
REQ-032 Words sent = ceil(size/4); for size = 0, RST is followed by DONE and no req is issued.
REQ-033 size = 65535 completes without counter wrap (16-bit bytes_left, no overflow).
REQ-034 Minimum latency per full word is 4 FILL cycles + 1 REQ cycle with immediate ack.

Reset
REQ-035 reset_n = 0 at a clock edge forces state IDLE and all of these to 0: host_bootdata, host_bootdata_req, host_bootdata_reset, byte_ready, busy, done, error, byte and timeout counters.
REQ-036 Reset mid-transfer (FILL or REQ) aborts the transfer: req drops on that edge and no done pulse is issued.
REQ-037 Reset overrides start when both are present in the same cycle.

Verification
REQ-038 size = 8, bytes 01..08 always valid, ack 2 cycles after each req -> one reset pulse, then words 0x01020304 and 0x05060708, then done; busy stays high throughout.
REQ-039 size = 5, bytes AA BB CC DD EE -> words 0xAABBCCDD and 0xEE000000; exactly 2 req/ack handshakes.
REQ-040 size = 0 -> host_bootdata_reset pulse, done one cycle later, host_bootdata_req never asserted.
REQ-041 ACK_TIMEOUT = 16, ack never asserted -> req high for 16 cycles, then req = 0, error = 1, busy = 0, no done; a following start clears error.
REQ-042 byte_valid toggled randomly, and start pulsed while busy -> words identical to the ungated run, and the second start has no effect.
REQ-043 reset_n = 0 while req is high during word 2 of 4 -> all outputs 0 next cycle; a new start restarts with a fresh reset pulse and the first word.
